// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP48A1 multiply-accumulate sequencer:
// operand/result widths, OPMODE encodings and the sequencer state encoding.
package dsp_pkg;

   localparam int OPND_W   = 18;
   localparam int PROD_W   = 36;
   localparam int P_W      = 48;
   localparam int OPMODE_W = 8;

   // Pre-adder, carry-in and subtract bits are always zero in these encodings.
   localparam logic [OPMODE_W-1:0] OPMODE_FIRST = 8'h01;  // X=M, Z=0
   localparam logic [OPMODE_W-1:0] OPMODE_ACC   = 8'h09;  // X=M, Z=P
   localparam logic [OPMODE_W-1:0] OPMODE_HOLD  = 8'h08;  // X=0, Z=P

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/dsp_mac_ctrl.sv
// Sequencer that streams signed operand pairs into a DSP48A1 slice as an N-tap
// MAC, waits out the slice pipeline and hands the 48-bit sum downstream.
module dsp_mac_ctrl
   import dsp_pkg::*;
#(
   parameter int N_TAPS = 8,
   parameter int LAT    = 3
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                S_VALID,
   output logic                S_READY,
   input  logic [OPND_W-1:0]   S_A,
   input  logic [OPND_W-1:0]   S_B,
   output logic [OPND_W-1:0]   A_OUT,
   output logic [OPND_W-1:0]   B_OUT,
   output logic [OPMODE_W-1:0] OPMODE_OUT,
   output logic                DSP_RST,
   output logic                DSP_CE,
   input  logic [P_W-1:0]      P_IN,
   output logic                M_VALID,
   input  logic                M_READY,
   output logic [P_W-1:0]      M_DATA,
   output logic                BUSY
);

   localparam int TAP_W = $clog2(N_TAPS + 1);
   localparam int DRN_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

   localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);
   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS);
   localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LAT);

   state_t                state_q, state_d;
   logic [TAP_W-1:0]      tap_q, tap_d;
   logic [DRN_W-1:0]      drn_q, drn_d;
   logic [OPND_W-1:0]     a_q, a_d;
   logic [OPND_W-1:0]     b_q, b_d;
   logic [OPMODE_W-1:0]   op_q, op_d;
   logic [P_W-1:0]        mdata_q, mdata_d;
   logic                  mvalid_q, mvalid_d;
   logic                  dsp_rst_q;

   logic                  s_ready;
   logic                  s_hs;
   logic [TAP_W-1:0]      tap_inc;

   // The slice is still being reset for one cycle after release, so no pair
   // may enter until that cycle is over.
   assign s_ready = ((state_q == IDLE) || (state_q == ACCUM)) && !dsp_rst_q;
   assign s_hs    = S_VALID && s_ready;
   assign tap_inc = tap_q + TAP_ONE;

   always_comb begin
      state_d  = state_q;
      tap_d    = tap_q;
      drn_d    = drn_q;
      a_d      = '0;
      b_d      = '0;
      op_d     = OPMODE_HOLD;
      mdata_d  = mdata_q;
      mvalid_d = mvalid_q;

      unique case (state_q)
         IDLE: begin
            if (s_hs) begin
               a_d   = S_A;
               b_d   = S_B;
               op_d  = OPMODE_FIRST;
               tap_d = TAP_ONE;
               drn_d = '0;
               state_d = (TAP_ONE >= TAP_LAST) ? DRAIN : ACCUM;
            end
         end
         ACCUM: begin
            if (s_hs) begin
               a_d   = S_A;
               b_d   = S_B;
               op_d  = OPMODE_ACC;
               tap_d = tap_inc;
               if (tap_inc == TAP_LAST) begin
                  drn_d   = '0;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // P_IN carries the final sum once the last pair has crossed the pipeline.
            if (drn_q == DRN_LAST) begin
               mdata_d  = P_IN;
               mvalid_d = 1'b1;
               state_d  = OUT;
            end else begin
               drn_d = drn_q + DRN_ONE;
            end
         end
         OUT: begin
            if (mvalid_q && M_READY) begin
               mvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         tap_q     <= '0;
         drn_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         mdata_q   <= '0;
         mvalid_q  <= 1'b0;
         dsp_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         tap_q     <= tap_d;
         drn_q     <= drn_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         mdata_q   <= mdata_d;
         mvalid_q  <= mvalid_d;
         dsp_rst_q <= 1'b0;
      end
   end

   assign S_READY    = s_ready;
   assign A_OUT      = a_q;
   assign B_OUT      = b_q;
   assign OPMODE_OUT = op_q;
   assign DSP_RST    = dsp_rst_q;
   assign DSP_CE     = !dsp_rst_q;
   assign M_VALID    = mvalid_q;
   assign M_DATA     = mdata_q;
   assign BUSY       = (state_q != IDLE);

endmodule
